// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises per-CPU icache/dcache requests onto a single-ported RAM
module mem_arbiter #(
  parameter int CPUS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0][31:0]  iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic                   ram_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t      state, next_state;
  logic        rr;
  logic        g_cpu, g_data, g_write;
  logic [31:0] g_addr, g_store;

  logic [CPUS-1:0] dreq;
  logic            any_d, any_i;
  logic            win_cpu, win_write;
  logic            grant, done;

  // Pick the winner among the current requests: data class first, rr breaks ties within a class.
  always_comb begin
    dreq      = dREN | dWEN;
    any_d     = |dreq;
    any_i     = |iREN;
    win_cpu   = 1'b0;
    if (any_d) begin
      win_cpu = (dreq[0] && dreq[1]) ? rr : dreq[1];
    end else if (any_i) begin
      win_cpu = (iREN[0] && iREN[1]) ? rr : iREN[1];
    end
    // dREN and dWEN together from one CPU counts as a write.
    win_write = any_d && dWEN[win_cpu];
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: grant only from IDLE, finish ACCESS on ram_ready, always spend one cycle in HOLD.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (any_d || any_i) begin
          next_state = ACCESS;
          grant      = 1'b1;
        end
      end
      ACCESS: begin
        if (ram_ready) begin
          next_state = HOLD;
          done       = 1'b1;
        end
      end
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the granted transaction and move rr to the CPU that lost.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr      <= 1'b0;
      g_cpu   <= 1'b0;
      g_data  <= 1'b0;
      g_write <= 1'b0;
      g_addr  <= 32'h0;
      g_store <= 32'h0;
    end else if (grant) begin
      rr      <= ~win_cpu;
      g_cpu   <= win_cpu;
      g_data  <= any_d;
      g_write <= win_write;
      g_addr  <= any_d ? daddr[win_cpu] : iaddr[win_cpu];
      g_store <= win_write ? dstore[win_cpu] : 32'h0;
    end
  end

  // RAM side: strobes follow the state so they drop straight away on reset.
  always_comb begin
    ramREN   = (state == ACCESS) && !g_write;
    ramWEN   = (state == ACCESS) && g_write;
    ramaddr  = g_addr;
    ramstore = g_store;
  end

  // Wait is released only for the granted port, only in its completing cycle.
  always_comb begin
    iwait = '1;
    dwait = '1;
    if (done) begin
      if (g_data) dwait[g_cpu] = 1'b0;
      else        iwait[g_cpu] = 1'b0;
    end
  end

  // Capture read data into the granted port's load register on completion.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iload <= '0;
      dload <= '0;
    end else if (done && !g_write) begin
      if (g_data) dload[g_cpu] <= ramload;
      else        iload[g_cpu] <= ramload;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int CPUS = 2;

  logic CLK = 1'b0;
  logic nRST;
  logic [1:0] iREN, dREN, dWEN, iwait, dwait;
  logic [1:0][31:0] iaddr, daddr, dstore, iload, dload;
  logic ramREN, ramWEN, ram_ready;
  logic [31:0] ramaddr, ramstore, ramload;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  // Ports: 0 = icache CPU0, 1 = icache CPU1, 2 = dcache CPU0, 3 = dcache CPU1.
  bit          req_on [4];
  bit          drv_on [4];
  bit          req_wr [4];
  bit          req_both [4];
  logic [31:0] req_addr [4];
  logic [31:0] req_data [4];
  bit          sticky;
  int          fixed_lat, cur_lat, ram_cnt, cyc;
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  typedef struct {
    int          port;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] data;
    int          cyc;
  } comp_t;
  comp_t comp_q [$];

  function automatic logic [31:0] mem_default(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] ram_rd(logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return mem_default(a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return mem_default(a);
  endfunction

  // Preferred CPU wins a tie; returns -1 when nobody asks.
  function automatic int pick(bit a, bit b, bit pref);
    if (a && b) return int'(pref);
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic do_reset();
    nRST = 1'b0;
    for (int p = 0; p < 4; p++) req_on[p] = 1'b0;
    sticky = 1'b0; ram_cnt = 0; fixed_lat = 1;
    iREN = '0; dREN = '0; dWEN = '0; iaddr = '0; daddr = '0; dstore = '0;
    ram_ready = 1'b0; ramload = 32'h0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  // One clock cycle: caches and RAM drive just after the edge, outputs sampled mid-cycle.
  task automatic env_cycle();
    @(posedge CLK); #1;
    cyc++;
    for (int c = 0; c < 2; c++) begin
      drv_on[c] = req_on[c]; drv_on[2+c] = req_on[2+c];
      iREN[c]   = req_on[c];
      iaddr[c]  = req_addr[c];
      dWEN[c]   = req_on[2+c] && req_wr[2+c];
      dREN[c]   = req_on[2+c] && (!req_wr[2+c] || req_both[2+c]);
      daddr[c]  = req_addr[2+c];
      dstore[c] = req_data[2+c];
    end
    if (ramREN || ramWEN) begin
      if (ram_cnt == 0) cur_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
      ram_ready = (ram_cnt == cur_lat - 1);
      ramload   = ram_ready ? ram_rd(ramaddr) : $urandom;
    end else begin
      ram_ready = 1'($urandom_range(0, 1));
      ramload   = $urandom;
    end
    #1;
    for (int p = 0; p < 4; p++) begin
      if (((p < 2) ? iwait[p] : dwait[p-2]) === 1'b0) begin
        comp_q.push_back('{port: p, addr: ramaddr, wr: ramWEN, data: ramstore, cyc: cyc});
        if (!sticky) req_on[p] = 1'b0;
      end
    end
    if (ramREN || ramWEN) begin
      if (ram_ready) begin
        if (ramWEN) ram_mem[ramaddr] = ramstore;
        ram_cnt = 0;
      end else begin
        ram_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #1;
    checks++; if (iwait !== 2'b11 || dwait !== 2'b11) begin failures++; $display("FAIL reset_wait: iwait=%b dwait=%b required 11 11", iwait, dwait); end
    checks++; if (iload !== '0 || dload !== '0) begin failures++; $display("FAIL reset_load: iload=%h dload=%h required 0", iload, dload); end
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin failures++; $display("FAIL reset_strobe: ren=%b wen=%b required 0 0", ramREN, ramWEN); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin failures++; $display("FAIL reset_ram_bus: addr=%h store=%h required 0 0", ramaddr, ramstore); end
    do_reset();
  endtask

  task automatic test_single_fetch();
    int pulses0 = 0, low1 = 0;
    do_reset(); comp_q.delete();
    ram_mem[32'h40] = 32'hDEADBEEF;
    req_on[0] = 1'b1; req_addr[0] = 32'h40;
    for (int n = 0; n < 6; n++) begin
      env_cycle();
      if (iwait[0] === 1'b0) pulses0++;
      if (iwait[1] !== 1'b1) low1++;
      if (n == 0) begin
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL fetch_idle_strobe: ren=%b required 0", ramREN); end
      end
      if (n == 1) begin
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin failures++; $display("FAIL fetch_access: ren=%b addr=%h required 1 00000040", ramREN, ramaddr); end
        checks++; if (iwait !== 2'b10) begin failures++; $display("FAIL fetch_wait: iwait=%b required 10", iwait); end
      end
      if (n >= 2) begin
        checks++; if (iload[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_load: iload0=%h required deadbeef", iload[0]); end
      end
    end
    checks++; if (pulses0 != 1) begin failures++; $display("FAIL fetch_pulse_count: got %0d required 1", pulses0); end
    checks++; if (low1 != 0) begin failures++; $display("FAIL fetch_other_wait: iwait1 low %0d cycles required 0", low1); end
  endtask

  task automatic test_priority();
    do_reset(); comp_q.delete();
    req_on[0] = 1'b1; req_addr[0] = 32'h44;
    req_on[3] = 1'b1; req_addr[3] = 32'h80;  req_wr[3] = 1'b0; req_both[3] = 1'b0;
    req_on[2] = 1'b1; req_addr[2] = 32'h100; req_wr[2] = 1'b1; req_both[2] = 1'b0; req_data[2] = 32'h5;
    repeat (12) env_cycle();
    checks++;
    if (comp_q.size() != 3) begin
      failures++; $display("FAIL prio_count: got %0d completions required 3", comp_q.size());
    end else begin
      checks++; if (comp_q[0].port != 2 || comp_q[0].addr !== 32'h100 || !comp_q[0].wr || comp_q[0].data !== 32'h5) begin failures++; $display("FAIL prio_first: port=%0d addr=%h wr=%0d data=%h required 2 100 1 5", comp_q[0].port, comp_q[0].addr, comp_q[0].wr, comp_q[0].data); end
      checks++; if (comp_q[1].port != 3 || comp_q[1].addr !== 32'h80 || comp_q[1].wr) begin failures++; $display("FAIL prio_second: port=%0d addr=%h wr=%0d required 3 80 0", comp_q[1].port, comp_q[1].addr, comp_q[1].wr); end
      checks++; if (comp_q[2].port != 0 || comp_q[2].addr !== 32'h44) begin failures++; $display("FAIL prio_third: port=%0d addr=%h required 0 44", comp_q[2].port, comp_q[2].addr); end
      checks++; if (comp_q[1].cyc - comp_q[0].cyc != 3 || comp_q[2].cyc - comp_q[1].cyc != 3) begin failures++; $display("FAIL prio_spacing: gaps %0d %0d required 3 3", comp_q[1].cyc - comp_q[0].cyc, comp_q[2].cyc - comp_q[1].cyc); end
    end
  endtask

  task automatic test_round_robin();
    do_reset(); comp_q.delete();
    sticky = 1'b1;
    req_on[0] = 1'b1; req_addr[0] = 32'h10;
    req_on[1] = 1'b1; req_addr[1] = 32'h20;
    repeat (12) env_cycle();
    sticky = 1'b0; req_on[0] = 1'b0; req_on[1] = 1'b0;
    checks++;
    if (comp_q.size() != 4) begin
      failures++; $display("FAIL rr_count: got %0d grants required 4", comp_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (comp_q[k].port != k % 2 || comp_q[k].addr !== ((k % 2) ? 32'h20 : 32'h10)) begin failures++; $display("FAIL rr_order[%0d]: port=%0d addr=%h required %0d", k, comp_q[k].port, comp_q[k].addr, k % 2); end
        if (k > 0) begin
          checks++; if (comp_q[k].cyc - comp_q[k-1].cyc != 3) begin failures++; $display("FAIL rr_spacing[%0d]: gap %0d required 3", k, comp_q[k].cyc - comp_q[k-1].cyc); end
        end
      end
    end
    repeat (3) env_cycle();
  endtask

  task automatic test_slow_ram();
    int stall = 0;
    do_reset(); comp_q.delete();
    fixed_lat = 6;
    req_on[3] = 1'b1; req_addr[3] = 32'h200; req_wr[3] = 1'b0; req_both[3] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      env_cycle();
      if (ramREN === 1'b1 && dwait[1] === 1'b1) begin
        stall++;
        checks++; if (ramaddr !== 32'h200 || ramWEN !== 1'b0) begin failures++; $display("FAIL slow_stable: addr=%h wen=%b required 200 0", ramaddr, ramWEN); end
      end
    end
    checks++; if (stall != 5) begin failures++; $display("FAIL slow_stall: got %0d stall cycles required 5", stall); end
    checks++; if (comp_q.size() != 1) begin failures++; $display("FAIL slow_done: got %0d completions required 1", comp_q.size()); end
    checks++; if (dload[1] !== mem_default(32'h200)) begin failures++; $display("FAIL slow_load: dload1=%h required %h", dload[1], mem_default(32'h200)); end
  endtask

  task automatic test_withdraw_reset();
    do_reset(); comp_q.delete();
    fixed_lat = 3;
    req_on[0] = 1'b1; req_addr[0] = 32'h300;
    repeat (2) env_cycle();
    req_on[0] = 1'b0;
    repeat (4) env_cycle();
    checks++; if (comp_q.size() != 1 || comp_q[0].port != 0) begin failures++; $display("FAIL withdraw_done: got %0d completions required 1 on port 0", comp_q.size()); end
    checks++; if (iload[0] !== mem_default(32'h300)) begin failures++; $display("FAIL withdraw_load: iload0=%h required %h", iload[0], mem_default(32'h300)); end
    fixed_lat = 4;
    req_on[0] = 1'b1; req_addr[0] = 32'h70;
    repeat (2) env_cycle();
    checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL midreset_pre: ren=%b required 1", ramREN); end
    nRST = 1'b0;
    #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin failures++; $display("FAIL midreset_strobe: ren=%b wen=%b required 0 0", ramREN, ramWEN); end
    checks++; if (iwait !== 2'b11 || dwait !== 2'b11) begin failures++; $display("FAIL midreset_wait: iwait=%b dwait=%b required 11 11", iwait, dwait); end
    checks++; if (iload !== '0 || dload !== '0) begin failures++; $display("FAIL midreset_load: iload=%h dload=%h required 0", iload, dload); end
    @(posedge CLK); #1 nRST = 1'b1;
    ram_cnt = 0; comp_q.delete(); fixed_lat = 1;
    req_on[0] = 1'b1; req_addr[0] = 32'h50;
    req_on[1] = 1'b1; req_addr[1] = 32'h60;
    repeat (4) env_cycle();
    checks++; if (comp_q.size() < 1 || comp_q[0].port != 0) begin failures++; $display("FAIL post_reset_rr: first grant port=%0d required 0", (comp_q.size() > 0) ? comp_q[0].port : -1); end
  endtask

  task automatic test_random();
    bit          m_busy = 0, m_hold = 0, m_rr = 0, m_wr = 0;
    int          m_port = 0, exp_low, dsel, isel, ncomp = 0;
    logic [31:0] m_addr = 0, m_data = 0;
    logic [31:0] ref_load [4];
    bit   [3:0]  wv;
    do_reset(); comp_q.delete();
    ram_mem.delete(); ref_mem.delete();
    fixed_lat = 0;
    for (int p = 0; p < 4; p++) ref_load[p] = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      env_cycle();
      for (int c = 0; c < 2; c++) begin
        checks++; if (iload[c] !== ref_load[c]) begin failures++; $display("FAIL rnd_iload%0d cyc %0d: got %h required %h", c, cyc, iload[c], ref_load[c]); end
        checks++; if (dload[c] !== ref_load[2+c]) begin failures++; $display("FAIL rnd_dload%0d cyc %0d: got %h required %h", c, cyc, dload[c], ref_load[2+c]); end
      end
      exp_low = -1;
      if (m_busy) begin
        checks++; if (ramREN !== !m_wr || ramWEN !== m_wr || ramaddr !== m_addr) begin failures++; $display("FAIL rnd_bus cyc %0d: ren=%b wen=%b addr=%h required %b %b %h", cyc, ramREN, ramWEN, ramaddr, !m_wr, m_wr, m_addr); end
        if (m_wr) begin
          checks++; if (ramstore !== m_data) begin failures++; $display("FAIL rnd_store cyc %0d: got %h required %h", cyc, ramstore, m_data); end
        end
        if (ram_ready) exp_low = m_port;
      end else begin
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin failures++; $display("FAIL rnd_idle_strobe cyc %0d: ren=%b wen=%b required 0 0", cyc, ramREN, ramWEN); end
      end
      wv = 4'b1111;
      if (exp_low >= 0) wv[exp_low] = 1'b0;
      checks++; if ({dwait, iwait} !== wv) begin failures++; $display("FAIL rnd_wait cyc %0d: got %b required %b", cyc, {dwait, iwait}, wv); end
      if (m_busy && ram_ready) begin
        if (m_wr) ref_mem[m_addr] = m_data;
        else      ref_load[m_port] = ref_rd(m_addr);
        m_busy = 0; m_hold = 1; ncomp++;
      end else if (!m_busy) begin
        if (m_hold) begin
          m_hold = 0;
        end else begin
          dsel = pick(drv_on[2], drv_on[3], m_rr);
          isel = pick(drv_on[0], drv_on[1], m_rr);
          if (dsel >= 0 || isel >= 0) begin
            m_port = (dsel >= 0) ? 2 + dsel : isel;
            m_wr   = req_wr[m_port] && (m_port >= 2);
            m_addr = req_addr[m_port];
            m_data = req_data[m_port];
            m_rr   = ((m_port % 2) == 0);
            m_busy = 1;
          end
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (!req_on[p]) begin
          if ($urandom_range(0, 9) < 3) begin
            req_on[p]   = 1'b1;
            req_addr[p] = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            req_wr[p]   = (p >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_both[p] = 1'($urandom_range(0, 1));
            req_data[p] = $urandom;
          end
        end else if ($urandom_range(0, 49) == 0) begin
          req_on[p] = 1'b0;
        end
      end
    end
    checks++; if (ncomp < 300) begin failures++; $display("FAIL rnd_progress: got %0d completions required at least 300", ncomp); end
  endtask

  initial begin
    cyc = 0; cur_lat = 1;
    for (int p = 0; p < 4; p++) begin
      req_addr[p] = 32'h0; req_data[p] = 32'h0; req_wr[p] = 1'b0; req_both[p] = 1'b0;
    end
    do_reset();
    test_reset();
    test_single_fetch();
    test_priority();
    test_round_robin();
    test_slow_ram();
    test_withdraw_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Responder side of the cache-to-memory request protocol. Accepts instruction-fetch requests (iREN/iaddr, answered with iwait/iload) and data requests (dREN/dWEN/daddr/dstore, answered with dwait/dload) from CPUS caches. It serialises them onto a single-ported RAM with variable latency and returns each result with the handshake the caches expect. It sits between the per-CPU icache/dcache pair and the RAM model.

## Interface
Parameters:
- CPUS, 2, number of requesting CPUs (each CPU has one icache and one dcache port); 2 is the only supported value.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  CPUS  instruction read request, per CPU
- iaddr  in  CPUS x 32  instruction word address, per CPU
- iwait  out  CPUS  instruction wait, 1 = not complete
- iload  out  CPUS x 32  instruction data returned, per CPU
- dREN  in  CPUS  data read request, per CPU
- dWEN  in  CPUS  data write request, per CPU
- daddr  in  CPUS x 32  data word address, per CPU
- dstore  in  CPUS x 32  data write value, per CPU
- dwait  out  CPUS  data wait, 1 = not complete
- dload  out  CPUS x 32  data read value, per CPU
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid when ram_ready = 1
- ram_ready  in  1  RAM access completes this cycle

## Operation
- FSM states: IDLE, ACCESS, HOLD.
- IDLE: sample all requests. If any request is pending, latch the grant (requester CPU, port type, op, address, store data) and go to ACCESS. Otherwise stay in IDLE.
- Arbitration priority: any data request beats any instruction request.
  - Within a class, a 1-bit round-robin pointer `rr` selects which CPU wins when both request. `rr` is the preferred CPU.
  - After every grant, `rr` is set to the CPU that did not win.
- Same CPU asserting dREN and dWEN together: treated as a write.
- ACCESS: drive ramaddr and ramstore from the latched grant. Drive ramREN (read) or ramWEN (write).
  - Hold these values until ram_ready = 1, then go to HOLD.
- HOLD: exactly one cycle with no RAM strobes and no arbitration, then IDLE. This stops a requester that is still asserting its request during its completion cycle from being granted twice.
- The granted requester's wait output is 0 only in the ACCESS cycle where ram_ready = 1. All other wait outputs are 1 at all times.
- Read completion: the ramload value present in the completing cycle is registered into that requester's iload or dload. It is held stable until that same port completes its next read.
- Write completion: no load register changes.
- Request withdrawn during ACCESS (e.g. PC reset): the RAM access runs to completion and the load register is still updated. There is no abort.
- Requests arriving during ACCESS or HOLD are not granted until the next IDLE cycle.
- Reset: state = IDLE, rr = 0, iwait = dwait = all 1, iload = dload = 0, ramREN = ramWEN = 0, ramaddr = ramstore = 0.

## Timing
- Minimum transaction: request seen in IDLE at cycle 0, ACCESS in cycle 1.
  - With ram_ready = 1 in cycle 1: wait = 0 in cycle 1, and the load register is valid from cycle 2 (HOLD).
  - Next grant is possible in IDLE at cycle 3, so back-to-back service is one grant every 3 cycles plus RAM latency.
- A RAM latency of N cycles with ram_ready high extends ACCESS by N-1 cycles.
- The wait-low pulse is combinational from ram_ready and the latched grant; it lasts exactly 1 cycle.
- The load output is registered: it is valid the cycle after wait falls and stays valid until overwritten. Caches sample it in the cycle after wait falls.
- Reset asserted mid-ACCESS: everything returns immediately to reset values, the RAM strobes drop asynchronously, and the partial access is discarded.

## Test plan
- Single fetch: CPU0 iREN=1, iaddr=0x40, ram_ready=1 with 1-cycle latency, ramload=0xDEADBEEF.
  - Required: ramREN=1 and ramaddr=0x40 in the cycle after the request.
  - iwait[0]=0 for exactly 1 cycle.
  - iload[0]=0xDEADBEEF from the next cycle onward; iwait[1] stays 1 throughout.
- Priority: in the same cycle, CPU0 iREN, CPU1 dREN (daddr=0x80), and CPU0 dWEN (daddr=0x100, dstore=0x5), with rr=0.
  - Required grant order: CPU0 write (0x100, ramWEN=1), then CPU1 read (0x80), then CPU0 fetch.
- Round-robin: both CPUs hold iREN continuously at 0x10 and 0x20.
  - Required: grants alternate CPU0, CPU1, CPU0, CPU1.
  - Each CPU gets exactly one iwait-low pulse per grant, and grants are 3 cycles apart with 1-cycle RAM latency.
- Slow RAM: ram_ready held low for 5 cycles during a CPU1 dREN.
  - Required: ramREN, ramaddr and dwait[1]=1 stay stable for all 5 cycles.
  - Completion follows on the 6th cycle and dload[1] updates.
- Withdrawn request and reset: CPU0 drops iREN during ACCESS.
  - Required: the access still completes and iload[0] updates.
  - Then assert nRST=0 mid-ACCESS of a new request. Required: ramREN=0, all waits=1 and all loads=0 immediately. After release, the first grant goes to CPU0 (rr=0).
